scan_mux: RTL and testbench

Parametrised N-channel, WIDTH-bit registered multiplexer with two modes. In manual mode it forwards a software-selected channel. In auto-scan mode it sequences through a channel-enable mask, holding each channel for a programmable dwell time. It replaces the fixed 16:1 one-bit combinational muxes wherever a registered, time-multiplexed channel sample stream is needed, for example feeding a shared monitor or serialiser.

---
 rtl/scan_mux.sv | 165 ++++++++++++++++
 tb/tb_scan_mux.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_mux.sv
// scan_mux: N-channel registered multiplexer.
// Manual mode forwards the channel picked by sel; scan mode walks the
// enabled channels in ascending order, presenting each for DWELL cycles,
// and flags the first sample of every pass after the first with wrap.
module scan_mux #(
  parameter int N_CH  = 16,
  parameter int WIDTH = 1,
  parameter int SEL_W = 4,
  parameter int DWELL = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH*WIDTH-1:0] din,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic [N_CH-1:0]       ch_en,
  input  logic                  start,
  output logic [WIDTH-1:0]      out,
  output logic [SEL_W-1:0]      out_ch,
  output logic                  out_valid,
  output logic                  wrap
);

  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  cur_ch_q, cur_ch_d;
  logic [DW_W-1:0]   dwell_q, dwell_d;
  logic              wrap_pend_q, wrap_pend_d;
  logic [WIDTH-1:0]  out_q, out_d;
  logic [SEL_W-1:0]  out_ch_q, out_ch_d;
  logic              valid_q, valid_d;
  logic              wrap_q, wrap_d;

  // Helper results shared by the next-state logic.
  logic [WIDTH-1:0]  sel_data, cur_data;
  logic              sel_en;
  logic [SEL_W-1:0]  first_en;
  logic [SEL_W-1:0]  above_en;
  logic              found_above;
  logic              any_en;

  assign any_en = |ch_en;

  // Channel lookups: data/enable at sel, data at cur_ch, and the circular search.
  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    sel_data    = '0;
    sel_en      = 1'b0;
    cur_data    = '0;
    first_en    = '0;
    above_en    = '0;
    found_above = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (sel == SEL_W'(i)) begin
        sel_data = din[i*WIDTH +: WIDTH];
        sel_en   = ch_en[i];
      end
      if (cur_ch_q == SEL_W'(i)) begin
        cur_data = din[i*WIDTH +: WIDTH];
      end
    end
    // Descending scans so the lowest qualifying index is the one left standing.
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (ch_en[i]) begin
        first_en = SEL_W'(i);
        if (SEL_W'(i) > cur_ch_q) begin
          above_en    = SEL_W'(i);
          found_above = 1'b1;
        end
      end
    end
  end

  // Next-state and output-register logic for the IDLE/SCAN controller.
  always_comb begin
    state_d     = state_q;
    cur_ch_d    = cur_ch_q;
    dwell_d     = dwell_q;
    wrap_pend_d = wrap_pend_q;
    out_d       = out_q;
    out_ch_d    = out_ch_q;
    valid_d     = 1'b0;
    wrap_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!mode) begin
          out_d    = sel_data;
          out_ch_d = sel;
          valid_d  = sel_en;
        end else if (start && any_en) begin
          state_d     = SCAN;
          cur_ch_d    = first_en;
          dwell_d     = '0;
          wrap_pend_d = 1'b0;
        end
      end
      SCAN: begin
        if (!mode) begin
          // Abort: this edge produces no valid sample, out/out_ch hold.
          state_d     = IDLE;
          wrap_pend_d = 1'b0;
        end else begin
          out_d    = cur_data;
          out_ch_d = cur_ch_q;
          valid_d  = 1'b1;
          wrap_d   = wrap_pend_q;
          if (dwell_q != DWELL_LAST) begin
            dwell_d     = dwell_q + DW_W'(1);
            wrap_pend_d = 1'b0;
          end else begin
            dwell_d = '0;
            if (!any_en) begin
              state_d     = IDLE;
              wrap_pend_d = 1'b0;
            end else begin
              // No enabled channel above cur_ch means the search wrapped round.
              cur_ch_d    = found_above ? above_en : first_en;
              wrap_pend_d = !found_above;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cur_ch_q    <= '0;
      dwell_q     <= '0;
      wrap_pend_q <= 1'b0;
      out_q       <= '0;
      out_ch_q    <= '0;
      valid_q     <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_ch_q    <= cur_ch_d;
      dwell_q     <= dwell_d;
      wrap_pend_q <= wrap_pend_d;
      out_q       <= out_d;
      out_ch_q    <= out_ch_d;
      valid_q     <= valid_d;
      wrap_q      <= wrap_d;
    end
  end

  assign out       = out_q;
  assign out_ch    = out_ch_q;
  assign out_valid = valid_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_scan_mux.sv
// Testbench for scan_mux: two instances (DWELL=1 and DWELL=3) share the
// same stimulus; expectations come from a pass/slot arithmetic model.
module tb_scan_mux;

  localparam int NCH = 16;
  localparam int W   = 8;
  localparam int SW  = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NCH*W-1:0] din = '0;
  logic            mode = 1'b0;
  logic [SW-1:0]   sel = '0;
  logic [NCH-1:0]  ch_en = '0;
  logic            start = 1'b0;

  logic [W-1:0]  o_out   [2];
  logic [SW-1:0] o_ch    [2];
  logic          o_valid [2];
  logic          o_wrap  [2];

  logic [W-1:0] din_v [NCH];
  int dwell_of [2] = '{1, 3};

  int checks = 0;
  int errors = 0;

  scan_mux #(.N_CH(NCH), .WIDTH(W), .SEL_W(SW), .DWELL(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .din(din), .mode(mode), .sel(sel),
    .ch_en(ch_en), .start(start), .out(o_out[0]), .out_ch(o_ch[0]),
    .out_valid(o_valid[0]), .wrap(o_wrap[0])
  );

  scan_mux #(.N_CH(NCH), .WIDTH(W), .SEL_W(SW), .DWELL(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .din(din), .mode(mode), .sel(sel),
    .ch_en(ch_en), .start(start), .out(o_out[1]), .out_ch(o_ch[1]),
    .out_valid(o_valid[1]), .wrap(o_wrap[1])
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pack_din();
    for (int i = 0; i < NCH; i++) din[i*W +: W] = din_v[i];
  endtask

  task automatic rand_din();
    for (int i = 0; i < NCH; i++) din_v[i] = 8'($urandom);
    pack_din();
  endtask

  // Abort any scan and settle in IDLE/manual.
  task automatic go_idle();
    mode  = 1'b0;
    start = 1'b0;
    step();
    step();
  endtask

  // Scan model: sample s (0-based from the first scan output) of a pass
  // over the enabled list, each channel held for d cycles.
  function automatic void model_slot(input int s, input int d, input int n,
                                     output int list_idx, output bit wr);
    int pos;
    pos      = s / d;
    list_idx = pos % n;
    wr       = ((pos / n) > 0) && (list_idx == 0) && ((s % d) == 0);
  endfunction

  task automatic test_reset();
    int lst[$];
    int li;
    bit wr;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (o_out[k] !== 8'h00 || o_ch[k] !== 4'h0 || o_valid[k] !== 1'b0 || o_wrap[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_init dut%0d: out=%h ch=%0d v=%b w=%b, expected all zero", k, o_out[k], o_ch[k], o_valid[k], o_wrap[k]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    // Start a scan then reset asynchronously in the middle of it.
    rand_din();
    ch_en = 16'h8421;
    mode  = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < NCH; i++) if (ch_en[i]) lst.push_back(i);
    for (int s = 0; s < 5; s++) begin
      step();
      model_slot(s, 1, lst.size(), li, wr);
      checks++;
      if (o_valid[0] !== 1'b1 || o_ch[0] !== SW'(lst[li])) begin
        errors++;
        $display("FAIL reset_prescan s=%0d: ch=%0d v=%b, expected ch=%0d v=1", s, o_ch[0], o_valid[0], lst[li]);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (o_out[k] !== 8'h00 || o_ch[k] !== 4'h0 || o_valid[k] !== 1'b0 || o_wrap[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_async dut%0d: out=%h ch=%0d v=%b w=%b, expected all zero", k, o_out[k], o_ch[k], o_valid[k], o_wrap[k]);
      end
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ch_en = 16'hFFFF;
    // Back in IDLE: no activity without a start.
    for (int s = 0; s < 3; s++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (o_valid[k] !== 1'b0 || o_wrap[k] !== 1'b0) begin
          errors++;
          $display("FAIL reset_idle dut%0d: v=%b w=%b, expected 0 0", k, o_valid[k], o_wrap[k]);
        end
      end
    end
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (o_valid[k] !== 1'b1 || o_ch[k] !== 4'd0 || o_out[k] !== din_v[0] || o_wrap[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_restart dut%0d: out=%h ch=%0d v=%b w=%b, expected %h 0 1 0", k, o_out[k], o_ch[k], o_valid[k], o_wrap[k], din_v[0]);
      end
    end
  endtask

  task automatic test_manual();
    go_idle();
    for (int i = 0; i < NCH; i++) din_v[i] = 8'hA0 + 8'(i);
    pack_din();
    sel   = 4'd5;
    ch_en = 16'hFFFF;
    step();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (o_out[k] !== 8'hA5 || o_ch[k] !== 4'd5 || o_valid[k] !== 1'b1 || o_wrap[k] !== 1'b0) begin
        errors++;
        $display("FAIL manual_sel5 dut%0d: out=%h ch=%0d v=%b w=%b, expected a5 5 1 0", k, o_out[k], o_ch[k], o_valid[k], o_wrap[k]);
      end
    end
    ch_en[5] = 1'b0;
    step();
    checks++;
    if (o_valid[0] !== 1'b0 || o_out[0] !== 8'hA5) begin
      errors++;
      $display("FAIL manual_disabled: out=%h v=%b, expected a5 0", o_out[0], o_valid[0]);
    end
    for (int t = 0; t < 24; t++) begin
      logic [SW-1:0] s;
      logic [NCH-1:0] m;
      rand_din();
      s = SW'($urandom);
      m = NCH'($urandom);
      sel   = s;
      ch_en = m;
      step();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (o_out[k] !== din_v[s] || o_ch[k] !== s || o_valid[k] !== m[s] || o_wrap[k] !== 1'b0) begin
          errors++;
          $display("FAIL manual_rand dut%0d t=%0d: out=%h ch=%0d v=%b w=%b, expected %h %0d %b 0", k, t, o_out[k], o_ch[k], o_valid[k], o_wrap[k], din_v[s], s, m[s]);
        end
      end
    end
  endtask

  // Start a scan with mask and compare ncyc samples on both instances.
  // A start pulse is re-issued mid-scan when restart_mid is set; it must be ignored.
  task automatic run_scan(input logic [NCH-1:0] mask, input int ncyc, input bit restart_mid, input string tag);
    int lst[$];
    int li;
    bit wr;
    go_idle();
    rand_din();
    ch_en = mask;
    mode  = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < NCH; i++) if (mask[i]) lst.push_back(i);
    for (int s = 0; s < ncyc; s++) begin
      start = restart_mid && (s == 4);
      step();
      for (int k = 0; k < 2; k++) begin
        model_slot(s, dwell_of[k], lst.size(), li, wr);
        checks++;
        if (o_valid[k] !== 1'b1 || o_ch[k] !== SW'(lst[li]) || o_out[k] !== din_v[lst[li]] || o_wrap[k] !== wr) begin
          errors++;
          $display("FAIL %s dut%0d s=%0d: out=%h ch=%0d v=%b w=%b, expected %h %0d 1 %b", tag, k, s, o_out[k], o_ch[k], o_valid[k], o_wrap[k], din_v[lst[li]], lst[li], wr);
        end
      end
    end
    start = 1'b0;
  endtask

  task automatic test_scan();
    run_scan(16'h8421, 14, 1'b0, "scan_8421");
    run_scan(16'h0008, 13, 1'b0, "scan_single");
    run_scan(16'h8001, 12, 1'b0, "scan_ends");
    for (int t = 0; t < 3; t++) begin
      logic [NCH-1:0] m;
      m = NCH'($urandom) | (NCH'(1) << $urandom_range(0, NCH - 1));
      run_scan(m, 40, 1'b1, "scan_rand");
    end
  endtask

  task automatic test_mask_clear();
    for (int t = 0; t < 3; t++) begin
      int lst[$];
      int li;
      int c0;
      bit wr;
      logic [NCH-1:0] m;
      go_idle();
      rand_din();
      m = NCH'($urandom) | NCH'(16'h0101);
      c0 = $urandom_range(0, 4);
      for (int i = 0; i < NCH; i++) if (m[i]) lst.push_back(i);
      ch_en = m;
      mode  = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int s = 0; s < 12; s++) begin
        step();
        for (int k = 0; k < 2; k++) begin
          int d;
          int last;
          d = dwell_of[k];
          // The slot in progress when the mask is cleared runs to its end.
          last = ((c0 + 2 + d - 1) / d) * d - 1;
          model_slot(s, d, lst.size(), li, wr);
          checks++;
          if (s <= last) begin
            if (o_valid[k] !== 1'b1 || o_ch[k] !== SW'(lst[li]) || o_wrap[k] !== wr) begin
              errors++;
              $display("FAIL mask_clear_run dut%0d s=%0d: ch=%0d v=%b w=%b, expected %0d 1 %b", k, s, o_ch[k], o_valid[k], o_wrap[k], lst[li], wr);
            end
          end else if (o_valid[k] !== 1'b0 || o_wrap[k] !== 1'b0) begin
            errors++;
            $display("FAIL mask_clear_idle dut%0d s=%0d: v=%b w=%b, expected 0 0", k, s, o_valid[k], o_wrap[k]);
          end
        end
        if (s == c0) ch_en = '0;
      end
    end
  endtask

  task automatic test_start_no_mask();
    go_idle();
    mode  = 1'b1;
    ch_en = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int s = 0; s < 4; s++) begin
      if (s == 2) ch_en = 16'hFFFF;
      step();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (o_valid[k] !== 1'b0 || o_wrap[k] !== 1'b0) begin
          errors++;
          $display("FAIL start_no_mask dut%0d s=%0d: v=%b w=%b, expected 0 0", k, s, o_valid[k], o_wrap[k]);
        end
      end
    end
  endtask

  task automatic test_abort();
    logic [SW-1:0] s;
    run_scan(16'hFFFF, 3, 1'b0, "abort_pre");
    s = SW'($urandom_range(0, NCH - 1));
    mode = 1'b0;
    sel  = s;
    step();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (o_valid[k] !== 1'b0 || o_wrap[k] !== 1'b0) begin
        errors++;
        $display("FAIL abort_edge dut%0d: v=%b w=%b, expected 0 0", k, o_valid[k], o_wrap[k]);
      end
    end
    step();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (o_valid[k] !== 1'b1 || o_ch[k] !== s || o_out[k] !== din_v[s]) begin
        errors++;
        $display("FAIL abort_manual dut%0d: out=%h ch=%0d v=%b, expected %h %0d 1", k, o_out[k], o_ch[k], o_valid[k], din_v[s], s);
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_manual();
    test_scan();
    test_mask_clear();
    test_start_no_mask();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
